adc_coeff_loader: RTL and testbench

Writer-side coefficient bank for the ADC correction engine. Accepts 32-bit coefficient, mean, reciprocal-stdev and section-limit words over a simple addressed write port into a shadow bank. On request, it atomically commits the shadow bank to the active bank that drives the engine's coefficient inputs. The commit waits until no sample is in flight inside the engine, so one sample never sees a mix of old and new coefficients.

---
 rtl/adc_coeff_loader.sv | 152 +++++++++++++++
 tb/tb_adc_coeff_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_coeff_loader.sv
// adc_coeff_loader: shadow/active coefficient bank with a commit that waits for the engine to drain.
// Optional readback port is enabled by defining ADC_COEFF_READBACK_EN.
module adc_coeff_loader #(
    parameter int CNT_W = 4
) (
    input  logic          sys_clk_i,
    input  logic          reset_i,
    input  logic          wr_en_i,
    input  logic [5:0]    wr_addr_i,
    input  logic [31:0]   wr_data_i,
    output logic          wr_rdy_o,
    output logic          wr_err_o,
    input  logic          commit_req_i,
    output logic          commit_done_o,
    output logic          hold_o,
    input  logic          eng_srdyi_i,
    input  logic          eng_srdyo_i,
    output logic [1407:0] coeff_o,
    output logic [127:0]  mean_o,
    output logic [127:0]  stdev_o,
    output logic [19:0]   section_limit_o
`ifdef ADC_COEFF_READBACK_EN
    ,
    input  logic          rd_en_i,
    input  logic [5:0]    rd_addr_i,
    input  logic          rd_active_i,
    output logic [31:0]   rd_data_o,
    output logic          rd_valid_o
`endif
);
    localparam int         NWORDS     = 52;
    localparam logic [5:0] ADDR_LIMIT = 6'd52;

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      shadow_q [NWORDS];
    logic [31:0]      active_q [NWORDS];
    logic [19:0]      shadow_lim_q, active_lim_q;
    logic             wr_err_q, commit_done_q;
    logic             wr_acc, commit_fire;

    assign wr_acc   = wr_en_i && (state_q == S_IDLE);
    assign wr_rdy_o = (state_q == S_IDLE);
    assign hold_o   = (state_q == S_PENDING);

    always_comb begin
        state_d     = state_q;
        commit_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (commit_req_i) state_d = S_PENDING;
            end
            S_PENDING: begin
                // A sample entering this very cycle still needs the old bank.
                if (cnt_q == '0 && !eng_srdyi_i) begin
                    commit_fire = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (eng_srdyi_i && !eng_srdyo_i && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
        else if (eng_srdyo_i && !eng_srdyi_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wr_err_q      <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_err_q      <= wr_acc && (wr_addr_i > ADDR_LIMIT);
            commit_done_q <= commit_fire;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NWORDS; i++) shadow_q[i] <= '0;
            shadow_lim_q <= '0;
        end else if (wr_acc) begin
            if (wr_addr_i < ADDR_LIMIT)
                shadow_q[wr_addr_i] <= wr_data_i;
            else if (wr_addr_i == ADDR_LIMIT)
                shadow_lim_q <= wr_data_i[19:0];
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NWORDS; i++) active_q[i] <= '0;
            active_lim_q <= '0;
        end else if (commit_fire) begin
            for (int i = 0; i < NWORDS; i++) active_q[i] <= shadow_q[i];
            active_lim_q <= shadow_lim_q;
        end
    end

    // Words 0..43 coeff, 44..47 mean, 48..51 reciprocal stdev.
    always_comb begin
        coeff_o = '0;
        mean_o  = '0;
        stdev_o = '0;
        for (int i = 0; i < 44; i++) coeff_o[32*i +: 32] = active_q[i];
        for (int s = 0; s < 4; s++) begin
            mean_o[32*s +: 32]  = active_q[44+s];
            stdev_o[32*s +: 32] = active_q[48+s];
        end
    end

    assign section_limit_o = active_lim_q;
    assign wr_err_o        = wr_err_q;
    assign commit_done_o   = commit_done_q;

`ifdef ADC_COEFF_READBACK_EN
    logic [31:0] rd_word;
    logic [31:0] rd_data_q;
    logic        rd_valid_q;

    always_comb begin
        rd_word = '0;
        if (rd_addr_i < ADDR_LIMIT)
            rd_word = rd_active_i ? active_q[rd_addr_i] : shadow_q[rd_addr_i];
        else if (rd_addr_i == ADDR_LIMIT)
            rd_word = {12'h0, (rd_active_i ? active_lim_q : shadow_lim_q)};
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) rd_data_q <= rd_word;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
`endif
endmodule

// File: tb/tb_adc_coeff_loader.sv
// Self-checking bench for adc_coeff_loader: bank model, commit scoreboard, drain/saturation cases.
// Readback cases are compiled in when ADC_COEFF_READBACK_EN is defined.
module tb_adc_coeff_loader;
  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          wr_en = 1'b0;
  logic [5:0]    wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          wr_rdy, wr_err;
  logic          commit_req = 1'b0;
  logic          commit_done, hold;
  logic          srdyi = 1'b0, srdyo = 1'b0;
  logic [1407:0] coeff;
  logic [127:0]  mean, stdev;
  logic [19:0]   sec_lim;
`ifdef ADC_COEFF_READBACK_EN
  logic          rd_en = 1'b0;
  logic [5:0]    rd_addr = '0;
  logic          rd_active = 1'b0;
  logic [31:0]   rd_data;
  logic          rd_valid;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_sh [53];
  logic [31:0] m_act [53];
  logic [31:0] exp_q [$];

  adc_coeff_loader #(.CNT_W(4)) dut (
    .sys_clk_i(clk), .reset_i(reset_i),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_rdy_o(wr_rdy), .wr_err_o(wr_err),
    .commit_req_i(commit_req), .commit_done_o(commit_done), .hold_o(hold),
    .eng_srdyi_i(srdyi), .eng_srdyo_i(srdyo),
    .coeff_o(coeff), .mean_o(mean), .stdev_o(stdev), .section_limit_o(sec_lim)
`ifdef ADC_COEFF_READBACK_EN
    , .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_active_i(rd_active),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_word(input int i);
    if (i < 44) return coeff[32*i +: 32];
    else if (i < 48) return mean[32*(i-44) +: 32];
    else if (i < 52) return stdev[32*(i-48) +: 32];
    else return {12'h0, sec_lim};
  endfunction

  function automatic logic [31:0] sig_model();
    logic [31:0] s = 32'h1;
    for (int i = 0; i < 53; i++) s = {s[30:0], s[31]} ^ m_sh[i];
    return s;
  endfunction

  function automatic logic [31:0] sig_dut();
    logic [31:0] s = 32'h1;
    for (int i = 0; i < 53; i++) s = {s[30:0], s[31]} ^ dut_word(i);
    return s;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 53; i++) begin
      m_sh[i] = '0;
      m_act[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic check_banks(input string tag);
    for (int i = 0; i < 53; i++) check($sformatf("%s_w%0d", tag, i), dut_word(i), m_act[i]);
  endtask

  // scoreboard: every commit_done pulse must match a queued shadow snapshot
  always @(negedge clk) begin
    if (!reset_i && commit_done) begin
      if (exp_q.size() == 0) check("commit_unexpected", 32'h1, 32'h0);
      else check("commit_sig", sig_dut(), exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic do_reset();
    reset_i = 1'b1;
    wr_en = 1'b0; commit_req = 1'b0; srdyi = 1'b0; srdyo = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;
    clear_model();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic acc);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (acc && a < 6'd52) m_sh[a] = d;
    else if (acc && a == 6'd52) m_sh[52] = {12'h0, d[19:0]};
    check($sformatf("wr_err_a%0h", a), {31'h0, wr_err}, {31'h0, (acc && a > 6'd52)});
  endtask

  task automatic req_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    exp_q.push_back(sig_model());
  endtask

  task automatic finish_commit(input string tag);
    check({tag, "_done"}, {31'h0, commit_done}, 32'h1);
    for (int i = 0; i < 53; i++) m_act[i] = m_sh[i];
    check_banks(tag);
  endtask

  task automatic commit_quick(input string tag);
    req_commit();
    check({tag, "_hold"}, {31'h0, hold}, 32'h1);
    check({tag, "_rdy"}, {31'h0, wr_rdy}, 32'h0);
    check({tag, "_early"}, {31'h0, commit_done}, 32'h0);
    tick();
    finish_commit(tag);
    tick();
    check({tag, "_drop"}, {31'h0, commit_done}, 32'h0);
    check({tag, "_idle"}, {31'h0, wr_rdy}, 32'h1);
  endtask

`ifdef ADC_COEFF_READBACK_EN
  task automatic rd(input logic [5:0] a, input logic act, input logic [31:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = a; rd_active = act;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, {31'h0, rd_valid}, 32'h1);
    check(tag, rd_data, exp);
    tick();
    check({tag, "_vdrop"}, {31'h0, rd_valid}, 32'h0);
  endtask
`endif

  initial begin
    do_reset();
    check("rst_rdy", {31'h0, wr_rdy}, 32'h1);
    check("rst_hold", {31'h0, hold}, 32'h0);
    check("rst_done", {31'h0, commit_done}, 32'h0);
    check("rst_err", {31'h0, wr_err}, 32'h0);
    check_banks("rst");

    // basic write + minimum-latency commit
    wr(6'h00, 32'h3F800000, 1'b1);
    wr(6'h34, 32'hFFFFF123, 1'b1);
    commit_quick("basic");
    check("basic_lim", {12'h0, sec_lim}, 32'h000FF123);

    // unmapped write, then a commit with no mapped changes
    wr(6'h3A, 32'hDEADBEEF, 1'b1);
    tick();
    check("err_drop", {31'h0, wr_err}, 32'h0);
    commit_quick("unmapped");

    // random writes, then drain three in-flight samples
    for (int i = 0; i < 10; i++) wr(6'($urandom_range(0, 52)), $urandom, 1'b1);
    wr(6'h34, 32'hABCDE987, 1'b1);
    for (int i = 0; i < 3; i++) begin
      srdyi = 1'b1; tick(); srdyi = 1'b0; tick();
    end
    req_commit();
    check("drain_hold", {31'h0, hold}, 32'h1);
    check("drain_rdy", {31'h0, wr_rdy}, 32'h0);
    wr(6'h05, 32'h55AA55AA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      srdyo = 1'b1; tick(); srdyo = 1'b0;
      check($sformatf("drain_wait%0d", i), {31'h0, commit_done}, 32'h0);
      check_banks($sformatf("drain_old%0d", i));
    end
    tick();
    finish_commit("drain");

    // simultaneous in/out keeps count; new input at count 0 blocks commit
    wr(6'h2D, $urandom, 1'b1);
    srdyi = 1'b1; tick(); srdyi = 1'b0;
    req_commit();
    srdyi = 1'b1; srdyo = 1'b1; tick(); srdyi = 1'b0; srdyo = 1'b0;
    check("both_nocommit", {31'h0, commit_done}, 32'h0);
    srdyo = 1'b1; tick(); srdyo = 1'b0;
    check("both_cnt0", {31'h0, commit_done}, 32'h0);
    srdyi = 1'b1; tick(); srdyi = 1'b0;
    check("late_in_block", {31'h0, commit_done}, 32'h0);
    srdyo = 1'b1; tick(); srdyo = 1'b0;
    check("late_in_drain", {31'h0, commit_done}, 32'h0);
    tick();
    finish_commit("both");

    // counter saturates at 15
    wr(6'h31, $urandom, 1'b1);
    srdyi = 1'b1; repeat (20) tick(); srdyi = 1'b0;
    req_commit();
    srdyo = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("sat_wait%0d", i), {31'h0, commit_done}, 32'h0);
    end
    srdyo = 1'b0;
    check("sat_hold", {31'h0, hold}, 32'h1);
    tick();
    finish_commit("sat");

    // decrement at zero is ignored
    srdyo = 1'b1; repeat (3) tick(); srdyo = 1'b0;
    srdyi = 1'b1; tick(); srdyi = 1'b0;
    req_commit();
    tick();
    check("dec0_block", {31'h0, commit_done}, 32'h0);
    srdyo = 1'b1; tick(); srdyo = 1'b0;
    check("dec0_wait", {31'h0, commit_done}, 32'h0);
    tick();
    finish_commit("dec0");

    // reset while pending
    wr(6'h2C, 32'h12345678, 1'b1);
    srdyi = 1'b1; tick(); srdyi = 1'b0;
    req_commit();
    tick();
    reset_i = 1'b1;
    tick();
    check("rstp_done", {31'h0, commit_done}, 32'h0);
    check("rstp_rdy", {31'h0, wr_rdy}, 32'h1);
    check("rstp_hold", {31'h0, hold}, 32'h0);
    check("rstp_mean", mean[31:0], 32'h0);
    reset_i = 1'b0;
    clear_model();
    commit_quick("post_rst");

`ifdef ADC_COEFF_READBACK_EN
    wr(6'h30, 32'hA5A5A5A5, 1'b1);
    wr(6'h34, 32'hFFF54321, 1'b1);
    rd(6'h30, 1'b0, 32'hA5A5A5A5, "rd_sh");
    rd(6'h30, 1'b1, 32'h0, "rd_act_pre");
    rd(6'h34, 1'b0, 32'h00054321, "rd_lim");
    rd(6'h3A, 1'b0, 32'h0, "rd_unmap");
    commit_quick("rd_commit");
    rd(6'h30, 1'b1, 32'hA5A5A5A5, "rd_act_post");
    rd_en = 1'b1; rd_addr = 6'h30; rd_active = 1'b0;
    wr(6'h30, 32'h5A5A5A5A, 1'b1);
    rd_en = 1'b0;
    check("rdw_old", rd_data, 32'hA5A5A5A5);
    rd(6'h30, 1'b0, 32'h5A5A5A5A, "rdw_new");
`endif

    repeat (2) tick();
    check("exp_q_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
